mul16_arbiter: RTL

Round-robin controller that shares one 16-bit sequential shift-add multiplier core among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes, sequences the core through load and run, and returns the 32-bit product with the requester ID over a single valid/ready result port. It sits between the multiplier clients and the `mul16_core` datapath. Only one multiplication is in flight at a time.

---
 rtl/mul_pkg.sv | 55 +++++
 rtl/mul16_core.sv | 68 ++++++
 rtl/mul16_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths, FSM state enum and round-robin pick for the multiplier arbiter
package mul_pkg;

  localparam int MUL_W     = 16;
  localparam int PROD_W    = 32;
  localparam int MUL_STEPS = 16;

  // rr_pick works on the largest supported requester count; callers zero-extend
  localparam int MAX_REQ = 8;
  localparam int MAX_IDW = 3;
  localparam int MAX_CW  = MAX_IDW + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } arb_state_e;

  // Rotate so ptr sits at bit 0, find the first set bit, rotate the index back.
  function automatic logic [MAX_IDW-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [MAX_IDW-1:0] ptr,
    input logic [MAX_CW-1:0]  n
  );
    logic [MAX_REQ-1:0] rot;
    logic [MAX_CW-1:0]  idx;
    logic [MAX_CW-1:0]  first;
    logic               found;
    rot   = '0;
    first = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = MAX_CW'(i) + {1'b0, ptr};
      if (idx >= n) begin
        idx = idx - n;
      end
      if (MAX_CW'(i) < n) begin
        rot[i] = valid[idx[MAX_IDW-1:0]];
      end
    end
    for (int i = 0; i < MAX_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        first = MAX_CW'(i);
      end
    end
    idx = first + {1'b0, ptr};
    if (idx >= n) begin
      idx = idx - n;
    end
    return idx[MAX_IDW-1:0];
  endfunction

endpackage

// File: rtl/mul16_core.sv
// rtl/mul16_core.sv - 16x16 unsigned shift-add multiplier, one step per cycle
module mul16_core
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  output logic [PROD_W-1:0] product,
  output logic              done
);

  localparam logic [4:0] LAST_STEP = 5'(MUL_STEPS - 1);

  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [MUL_W-1:0]  mplier_q, mplier_d;
  logic [4:0]        step_q, step_d;
  logic              active_q, active_d;
  logic [PROD_W-1:0] acc_step;

  // The last step is folded combinationally so the product is valid with done.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product  = acc_step;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    step_d   = step_q;
    active_d = active_q;
    done     = 1'b0;
    if (load) begin
      acc_d    = '0;
      mcand_d  = PROD_W'(a);
      mplier_d = b;
      step_d   = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      step_d   = step_q + 5'd1;
      if (step_q == LAST_STEP) begin
        done     = 1'b1;
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      step_q   <= '0;
      active_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      step_q   <= step_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/mul16_arbiter.sv
// rtl/mul16_arbiter.sv - round-robin sharing of one mul16_core among NREQ requesters
module mul16_arbiter
  import mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*MUL_W-1:0] req_a,
  input  logic [NREQ*MUL_W-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  output logic [PROD_W-1:0]     res_data,
  output logic [IDW-1:0]        res_id,
  input  logic                  res_ready,
  output logic                  busy
);

  localparam logic [MAX_CW-1:0] NREQ_N   = MAX_CW'(NREQ);
  localparam logic [IDW-1:0]    LAST_REQ = IDW'(NREQ - 1);

  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [MUL_W-1:0]  a_q, a_d;
  logic [MUL_W-1:0]  b_q, b_d;
  logic [PROD_W-1:0] res_q, res_d;
  logic [MAX_IDW-1:0] pick;
  logic [IDW-1:0]    grant;
  logic              core_load;
  logic              core_done;
  logic [PROD_W-1:0] core_product;

  assign pick  = rr_pick(MAX_REQ'(req_valid), MAX_IDW'(rr_ptr_q), NREQ_N);
  assign grant = IDW'(pick);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    req_ready = '0;
    core_load = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // rst_n gate keeps req_ready low while reset holds the FSM in IDLE
        if (|req_valid && rst_n) begin
          req_ready[grant] = 1'b1;
          a_d      = req_a[int'(grant)*MUL_W +: MUL_W];
          b_d      = req_b[int'(grant)*MUL_W +: MUL_W];
          id_d     = grant;
          rr_ptr_d = (grant == LAST_REQ) ? '0 : grant + 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        core_load = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        if (core_done) begin
          res_d   = core_product;
          state_d = RESP;
        end
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign res_data = res_q;
  assign res_id   = id_q;

  mul16_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (core_load),
    .a       (a_q),
    .b       (b_q),
    .product (core_product),
    .done    (core_done)
  );

endmodule
